// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions: sizes, rc(t) LFSR constants, lane type,
// round-constant FSM states and the small LFSR / RC expansion helpers.
package keccak_pkg;

  localparam int STATE_SIZE    = 1600;
  localparam int Z_WIDTH       = 64;
  localparam int KECCAK_ROUNDS = 24;

  localparam logic [7:0] RC_LFSR_POLY = 8'h71;
  localparam logic [7:0] RC_LFSR_INIT = 8'h01;

  // Lane as seen by the iota step: index 63 is bit 0 of the lane.
  typedef logic [0:63] lane_t;

  typedef enum logic [1:0] {
    RC_IDLE   = 2'd0,
    RC_SKIP   = 2'd1,
    RC_ACTIVE = 2'd2,
    RC_FINISH = 2'd3
  } rc_state_e;

  // One step of the rc(t) LFSR; the output bit is r[0] before stepping.
  function automatic logic [7:0] rc_lfsr_step(input logic [7:0] r);
    logic [7:0] poly;
    if (r[7]) begin
      poly = RC_LFSR_POLY;
    end else begin
      poly = 8'h00;
    end
    return {r[6:0], 1'b0} ^ poly;
  endfunction

  // Scatter the seven round bits onto lane bits 2^j-1; every other bit is zero.
  function automatic lane_t rc_expand(input logic [6:0] b);
    logic [63:0] v;
    v     = 64'h0000_0000_0000_0000;
    v[0]  = b[0];
    v[1]  = b[1];
    v[3]  = b[2];
    v[7]  = b[3];
    v[15] = b[4];
    v[31] = b[5];
    v[63] = b[6];
    return v;
  endfunction

endpackage

// File: rtl/keccak_rc_lfsr_step7.sv
// Seven chained rc(t) LFSR steps: one Keccak round worth of constant bits.
module keccak_rc_lfsr_step7
  import keccak_pkg::*;
(
  input  logic [7:0] r,
  output logic [7:0] r_next,
  output logic [6:0] bits
);

  logic [7:0] walk_s;

  // Collect the output bit ahead of each of the seven steps.
  always_comb begin
    walk_s = r;
    bits   = 7'h00;
    for (int j = 0; j < 7; j++) begin
      bits[j] = walk_s[0];
      walk_s  = rc_lfsr_step(walk_s);
    end
    r_next = walk_s;
  end

endmodule

// File: rtl/keccak_rc_gen.sv
// Sequential iota round-constant source. lfsr_r always holds the LFSR state
// for the round after round_r, so a single seven-step block serves both the
// fast-forward (SKIP) and the normal ADVANCE path.
module keccak_rc_gen
  import keccak_pkg::*;
#(
  parameter int Z_WIDTH    = 64,
  parameter int NUM_ROUNDS = 24
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic               ADVANCE,
  output logic [0:Z_WIDTH-1] RC_CONSTANT,
  output logic [4:0]         ROUND_IDX,
  output logic               RC_VALID,
  output logic               LAST_ROUND,
  output logic               DONE
);

  localparam logic [4:0] SKIP_ROUNDS = 5'(KECCAK_ROUNDS - NUM_ROUNDS);
  localparam logic [4:0] LAST_IDX    = 5'(KECCAK_ROUNDS - 1);

  rc_state_e  state_r, state_s;
  logic [7:0] lfsr_r, lfsr_s;
  logic [4:0] round_r, round_s, round_inc_s;
  lane_t      rc_r, rc_s, step_lane_s;
  logic       valid_r, valid_s;
  logic       last_r, last_s;
  logic       done_r, done_s;
  logic [7:0] step_in_s, step_next_s;
  logic [6:0] step_bits_s;

  // A new permutation always restarts the LFSR from its seed.
  always_comb begin
    if (START) begin
      step_in_s = RC_LFSR_INIT;
    end else begin
      step_in_s = lfsr_r;
    end
  end

  keccak_rc_lfsr_step7 u_step7 (
    .r      (step_in_s),
    .r_next (step_next_s),
    .bits   (step_bits_s)
  );

  assign step_lane_s = rc_expand(step_bits_s);
  assign round_inc_s = round_r + 5'd1;

  // Next-state logic: START has priority over everything except reset.
  always_comb begin
    state_s = state_r;
    lfsr_s  = lfsr_r;
    round_s = round_r;
    rc_s    = rc_r;
    valid_s = valid_r;
    done_s  = 1'b0;
    if (START) begin
      lfsr_s  = step_next_s;
      round_s = 5'd0;
      if (SKIP_ROUNDS == 5'd0) begin
        state_s = RC_ACTIVE;
        rc_s    = step_lane_s;
        valid_s = 1'b1;
      end else begin
        state_s = RC_SKIP;
        valid_s = 1'b0;
      end
    end else begin
      case (state_r)
        RC_IDLE: begin
          valid_s = 1'b0;
        end
        RC_SKIP: begin
          lfsr_s  = step_next_s;
          round_s = round_inc_s;
          if (round_inc_s == SKIP_ROUNDS) begin
            state_s = RC_ACTIVE;
            rc_s    = step_lane_s;
            valid_s = 1'b1;
          end else begin
            valid_s = 1'b0;
          end
        end
        RC_ACTIVE: begin
          if (ADVANCE) begin
            if (round_r == LAST_IDX) begin
              state_s = RC_FINISH;
              valid_s = 1'b0;
              done_s  = 1'b1;
            end else begin
              lfsr_s  = step_next_s;
              round_s = round_inc_s;
              rc_s    = step_lane_s;
              valid_s = 1'b1;
            end
          end else begin
            valid_s = 1'b1;
          end
        end
        RC_FINISH: begin
          state_s = RC_IDLE;
          valid_s = 1'b0;
        end
        default: begin
          state_s = RC_IDLE;
          valid_s = 1'b0;
        end
      endcase
    end
    if (valid_s && (round_s == LAST_IDX)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= RC_IDLE;
      lfsr_r  <= RC_LFSR_INIT;
      round_r <= 5'd0;
      rc_r    <= 64'h0000_0000_0000_0000;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      lfsr_r  <= lfsr_s;
      round_r <= round_s;
      rc_r    <= rc_s;
      valid_r <= valid_s;
      last_r  <= last_s;
      done_r  <= done_s;
    end
  end

  assign RC_CONSTANT = rc_r;
  assign ROUND_IDX   = round_r;
  assign RC_VALID    = valid_r;
  assign LAST_ROUND  = last_r;
  assign DONE        = done_r;

endmodule
